sd_cmd_engine: RTL and testbench
================================

SD_CMD_ENGINE -- requirements
Module: sd_cmd_engine

Interface
REQ-001 Parameter PRE_CLKS, default 8: SD_CLK cycles with SD_IN high and SD_CS low before each frame, and again after each frame.
REQ-002 Parameter RESP_WAIT, default 64: maximum SD_OUT samples spent looking for the response start bit.
REQ-003 SD_CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  command request; sampled only in IDLE.
REQ-006 cmd_idx  input  6  command index.
REQ-007 cmd_arg  input  32  command argument.
REQ-008 cmd_crc  input  7  CRC7 field, supplied by the requester, not computed here.
REQ-009 resp_long  input  1  0 = R1 response (8 bits); 1 = R7 response (40 bits).
REQ-010 SD_OUT  input  1  serial data from card (card data-out).
REQ-011 SD_IN  output  1  serial data to card (card data-in).
REQ-012 SD_CS  output  1  active-low card select.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 timeout  output  1  no start bit found; valid while done=1.
REQ-016 resp  output  40  captured response; R1 right-aligned in [7:0] with [39:8]=0.

Function
REQ-017 FSM states: IDLE, PRE, SEND, WAIT, RECV, POST.
REQ-018 IDLE, start=1: latch frame = {2'b01, cmd_idx, cmd_arg, cmd_crc, 1'b1} (48 bits) and resp_long, clear resp, go to PRE; busy=1 and SD_CS=0 from the next cycle.
REQ-019 PRE: hold SD_IN=1 for exactly PRE_CLKS cycles, then go to SEND.
REQ-020 SEND: drive frame MSB first, one bit per cycle for 48 cycles (first bit 0, last bit 1), then go to WAIT with SD_IN=1.
REQ-021 WAIT: sample SD_OUT each cycle; the first 0 sample is response bit MSB (bit 7 for R1, bit 39 for R7), stored, go to RECV; after RESP_WAIT samples all 1, set timeout flag, resp=40'hFF_FFFF_FFFF, go to POST.
REQ-022 RECV: shift in the remaining 7 bits (R1) or 39 bits (R7) MSB first, one per cycle, then go to POST.
REQ-023 POST: SD_IN=1, SD_CS=0 for PRE_CLKS cycles, then go to IDLE; SD_CS=1 and busy=0 from that same cycle, with done=1 for exactly that one cycle.
REQ-024 timeout output mirrors the timeout flag from POST exit until the next accepted start; the flag clears on acceptance.
REQ-025 resp holds its value from POST exit until the next accepted start.
REQ-026 start while busy=1 is ignored; no queuing.
REQ-027 start asserted in the cycle done=1 is accepted (IDLE state).
REQ-028 SD_IN is 1 in every state other than SEND.
REQ-029 Counters are sized to hold max(48, RESP_WAIT, PRE_CLKS) without wrap.
REQ-030 Total cycles from start to done for R1 with the start bit on sample k (1..RESP_WAIT): 1+PRE_CLKS+48+k+7+PRE_CLKS; for R7, replace 7 with 39.

Reset
REQ-031 rst=1 forces, asynchronously: state IDLE, SD_CS=1, SD_IN=1, busy=0, done=0, timeout=0, resp=0, all counters 0.
REQ-032 rst during any state aborts the transaction; no done pulse is produced, and the first start after release begins a fresh transaction.

Verification
REQ-033 CMD0: idx=0, arg=0, crc=7'h4A, resp_long=0; card returns 0x01 on sample 3 -> SD_IN bits 0x40_0000_0000_95, resp=40'h01, timeout=0, done at cycle 1+8+48+3+7+8=75.
REQ-034 CMD8: idx=8, arg=32'h1AA, crc=7'h43, resp_long=1; card returns 40'h01_0000_01AA -> resp=40'h01_0000_01AA, timeout=0.
REQ-035 SD_OUT held 1 -> done at cycle 1+8+48+64+8=129, timeout=1, resp=40'hFF_FFFF_FFFF.
REQ-036 Second start pulsed mid-SEND -> ignored; exactly one done; SD_IN frame is unchanged.
REQ-037 rst pulsed mid-SEND (bit 20) -> SD_CS=1 and SD_IN=1 immediately, no done; next start completes CMD0 normally.
REQ-038 start held high continuously -> back-to-back transactions; each done cycle is followed directly by a new busy=1.

Source files
------------

// File: rtl/sd_cmd_engine_if.sv
// sd_cmd_engine_if
// Groups the request, serial-line and status signals of the SD command
// engine into one bundle.
//   start/cmd_idx/cmd_arg/cmd_crc/resp_long : command request from the host
//   SD_OUT                                  : serial data returned by the card
//   SD_IN/SD_CS                             : serial data and select to the card
//   busy/done/timeout/resp                  : engine status and captured response
// Modports: slave = the engine, master = the requester / card model.
interface sd_cmd_engine_if;
    logic        start;
    logic [5:0]  cmd_idx;
    logic [31:0] cmd_arg;
    logic [6:0]  cmd_crc;
    logic        resp_long;
    logic        SD_OUT;
    logic        SD_IN;
    logic        SD_CS;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [39:0] resp;

    modport slave (
        input  start, cmd_idx, cmd_arg, cmd_crc, resp_long, SD_OUT,
        output SD_IN, SD_CS, busy, done, timeout, resp
    );

    modport master (
        output start, cmd_idx, cmd_arg, cmd_crc, resp_long, SD_OUT,
        input  SD_IN, SD_CS, busy, done, timeout, resp
    );
endinterface

// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine
// Sends one 48-bit SD command frame in SPI mode and captures the R1 (8-bit)
// or R7 (40-bit) response, bracketed by PRE_CLKS idle clocks with the card
// selected before and after the frame.
// Ports:
//   SD_CLK : sole clock, rising edge
//   rst    : asynchronous active-high reset
//   sd_bus : sd_cmd_engine_if.slave (request, serial lines, status)
// Parameters:
//   PRE_CLKS  : idle clocks (SD_IN=1, SD_CS=0) before and after the frame
//   RESP_WAIT : maximum SD_OUT samples spent looking for the response start bit
module sd_cmd_engine #(
    parameter int PRE_CLKS  = 8,
    parameter int RESP_WAIT = 64
) (
    input  logic              SD_CLK,
    input  logic              rst,
    sd_cmd_engine_if.slave    sd_bus
);

    localparam int CNT_MAX = (48 > RESP_WAIT)
                           ? ((48 > PRE_CLKS) ? 48 : PRE_CLKS)
                           : ((RESP_WAIT > PRE_CLKS) ? RESP_WAIT : PRE_CLKS);
    localparam int CW = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SEND,
        ST_WAIT,
        ST_RECV,
        ST_POST
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [47:0]   r_frame;
    logic          r_resp_long;
    logic          r_to_flag;
    logic          r_sd_in;
    logic          r_sd_cs;
    logic          r_busy;
    logic          r_done;
    logic          r_timeout;
    logic [39:0]   r_resp;

    logic w_pre_last;
    logic w_send_last;
    logic w_wait_last;
    logic w_recv_last;

    assign w_pre_last  = (r_cnt == CW'(PRE_CLKS - 1));
    assign w_send_last = (r_cnt == CW'(47));
    assign w_wait_last = (r_cnt == CW'(RESP_WAIT - 1));
    // The start bit was already taken in WAIT, so RECV only needs len-1 bits.
    assign w_recv_last = r_resp_long ? (r_cnt == CW'(38)) : (r_cnt == CW'(6));

    always_ff @(posedge SD_CLK or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_frame     <= '0;
            r_resp_long <= 1'b0;
            r_to_flag   <= 1'b0;
            r_sd_in     <= 1'b1;
            r_sd_cs     <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_resp      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (sd_bus.start) begin
                        r_frame     <= {2'b01, sd_bus.cmd_idx, sd_bus.cmd_arg,
                                        sd_bus.cmd_crc, 1'b1};
                        r_resp_long <= sd_bus.resp_long;
                        r_resp      <= '0;
                        r_to_flag   <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_busy      <= 1'b1;
                        r_sd_cs     <= 1'b0;
                        r_sd_in     <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ST_PRE;
                    end
                end

                ST_PRE: begin
                    if (w_pre_last) begin
                        // Present the first frame bit in the first SEND cycle.
                        r_sd_in <= r_frame[47];
                        r_frame <= {r_frame[46:0], 1'b0};
                        r_cnt   <= '0;
                        r_state <= ST_SEND;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_SEND: begin
                    if (w_send_last) begin
                        r_sd_in <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_WAIT;
                    end else begin
                        r_sd_in <= r_frame[47];
                        r_frame <= {r_frame[46:0], 1'b0};
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end

                ST_WAIT: begin
                    if (!sd_bus.SD_OUT) begin
                        // The start bit is the response MSB; shifting it into
                        // the cleared register keeps R1 right-aligned later.
                        r_resp  <= {r_resp[38:0], 1'b0};
                        r_cnt   <= '0;
                        r_state <= ST_RECV;
                    end else if (w_wait_last) begin
                        r_to_flag <= 1'b1;
                        r_resp    <= '1;
                        r_cnt     <= '0;
                        r_state   <= ST_POST;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_RECV: begin
                    r_resp <= {r_resp[38:0], sd_bus.SD_OUT};
                    if (w_recv_last) begin
                        r_cnt   <= '0;
                        r_state <= ST_POST;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_POST: begin
                    if (w_pre_last) begin
                        r_sd_cs   <= 1'b1;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= r_to_flag;
                        r_cnt     <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_sd_in <= 1'b1;
                    r_sd_cs <= 1'b1;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign sd_bus.SD_IN   = r_sd_in;
    assign sd_bus.SD_CS   = r_sd_cs;
    assign sd_bus.busy    = r_busy;
    assign sd_bus.done    = r_done;
    assign sd_bus.timeout = r_timeout;
    assign sd_bus.resp    = r_resp;

endmodule

// File: tb/tb_sd_cmd_engine.sv
module tb_sd_cmd_engine;

    localparam int P  = 8;
    localparam int RW = 64;

    logic SD_CLK = 1'b0;
    logic rst    = 1'b1;

    sd_cmd_engine_if bus_if ();

    sd_cmd_engine #(
        .PRE_CLKS  (P),
        .RESP_WAIT (RW)
    ) dut (
        .SD_CLK (SD_CLK),
        .rst    (rst),
        .sd_bus (bus_if)
    );

    always #5 SD_CLK = ~SD_CLK;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg,
                                                input logic [6:0] crc);
        return {2'b01, idx, arg, crc, 1'b1};
    endfunction

    // One complete transaction, entered and left at a falling edge with the
    // DUT idle. The card answers with its start bit on sample k (k=0 or
    // k>RW means the card never answers). extra_at>0 pulses a second start
    // in that cycle, which must be ignored.
    task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                           input logic long_r, input int k, input logic [39:0] rv,
                           input int extra_at, input string tag);
        logic [39:0] card_word;
        logic [39:0] exp_resp;
        logic [47:0] fr_obs;
        logic        exp_to;
        logic        bad_busy;
        logic        bad_in;
        int          len;
        int          exp_lat;
        int          done_at;
        int          bit_pos;

        len       = long_r ? 40 : 8;
        card_word = long_r ? {1'b0, rv[38:0]} : {32'b0, 1'b0, rv[6:0]};
        exp_to    = (k < 1) || (k > RW);
        exp_lat   = exp_to ? (1 + P + 48 + RW + P) : (1 + P + 48 + k + (len - 1) + P);
        exp_resp  = exp_to ? 40'hFF_FFFF_FFFF : card_word;

        bus_if.cmd_idx   = idx;
        bus_if.cmd_arg   = arg;
        bus_if.cmd_crc   = crc;
        bus_if.resp_long = long_r;
        bus_if.SD_OUT    = 1'b1;
        bus_if.start     = 1'b1;

        done_at  = -1;
        fr_obs   = '0;
        bad_busy = 1'b0;
        bad_in   = 1'b0;
        for (int n = 1; n <= 300 && done_at < 0; n++) begin
            @(negedge SD_CLK);
            bus_if.start = (n == extra_at);
            if (n == 1) begin
                // Request inputs may change once accepted.
                bus_if.cmd_idx   = 6'($urandom);
                bus_if.cmd_arg   = $urandom;
                bus_if.cmd_crc   = 7'($urandom);
                bus_if.resp_long = ~long_r;
            end
            bit_pos = n - (P + 48) - k;
            if (!exp_to && bit_pos >= 0 && bit_pos < len)
                bus_if.SD_OUT = card_word[len - 1 - bit_pos];
            else
                bus_if.SD_OUT = 1'b1;

            if (bus_if.done === 1'b1) begin
                done_at = n;
            end else begin
                if (bus_if.busy !== 1'b1 || bus_if.SD_CS !== 1'b0) bad_busy = 1'b1;
                if (n >= P + 1 && n <= P + 48)
                    fr_obs = {fr_obs[46:0], bus_if.SD_IN};
                else if (bus_if.SD_IN !== 1'b1)
                    bad_in = 1'b1;
            end
        end
        bus_if.start  = 1'b0;
        bus_if.SD_OUT = 1'b1;

        chk({tag, " latency"},   64'(done_at), 64'(exp_lat));
        chk({tag, " frame"},     64'(fr_obs), 64'(model_frame(idx, arg, crc)));
        chk({tag, " busy_cs"},   64'(bad_busy), 64'(0));
        chk({tag, " sdin_idle"}, 64'(bad_in), 64'(0));
        chk({tag, " resp"},      64'(bus_if.resp), 64'(exp_resp));
        chk({tag, " timeout"},   64'(bus_if.timeout), 64'(exp_to));
        chk({tag, " done_st"},   64'({bus_if.busy, bus_if.SD_CS}), 64'(2'b01));

        @(negedge SD_CLK);
        chk({tag, " after"},     64'({bus_if.done, bus_if.busy}), 64'(2'b00));
        chk({tag, " resp_hold"}, 64'(bus_if.resp), 64'(exp_resp));
        $display("txn %s idx=%0d long=%0b k=%0d latency=%0d resp=%h timeout=%0b",
                 tag, idx, long_r, k, done_at, bus_if.resp, bus_if.timeout);
    endtask

    initial begin
        logic [47:0] fr;
        int          first_done;
        int          second_done;
        logic        saw_done;
        logic [5:0]  r_idx;
        logic [31:0] r_arg;
        logic [6:0]  r_crc;
        logic        r_long;
        int          r_k;
        logic [39:0] r_rv;
        int          r_extra;

        bus_if.start     = 1'b0;
        bus_if.cmd_idx   = '0;
        bus_if.cmd_arg   = '0;
        bus_if.cmd_crc   = '0;
        bus_if.resp_long = 1'b0;
        bus_if.SD_OUT    = 1'b1;

        // Reset values
        #12;
        chk("reset flags", 64'({bus_if.SD_CS, bus_if.SD_IN, bus_if.busy, bus_if.done, bus_if.timeout}),
            64'(5'b11000));
        chk("reset resp", 64'(bus_if.resp), 64'(0));
        @(negedge SD_CLK);
        rst = 1'b0;
        @(negedge SD_CLK);

        // CMD0, R1=0x01 on sample 3
        run_txn(6'd0, 32'h0, 7'h4A, 1'b0, 3, 40'h01, 0, "cmd0");
        // CMD8, R7
        run_txn(6'd8, 32'h1AA, 7'h43, 1'b1, 5, 40'h01_0000_01AA, 0, "cmd8");
        // Card never answers
        run_txn(6'd0, 32'h0, 7'h4A, 1'b0, 0, 40'h0, 0, "timeout");
        // Start pulsed mid-SEND is ignored
        run_txn(6'd0, 32'h0, 7'h4A, 1'b0, 3, 40'h01, P + 22, "ignored_start");

        // Reset asserted while frame bit 20 is on SD_IN
        fr = model_frame(6'd0, 32'h0, 7'h4A);
        bus_if.cmd_idx   = 6'd0;
        bus_if.cmd_arg   = 32'h0;
        bus_if.cmd_crc   = 7'h4A;
        bus_if.resp_long = 1'b0;
        bus_if.start     = 1'b1;
        for (int n = 1; n <= P + 21; n++) begin
            @(negedge SD_CLK);
            bus_if.start = 1'b0;
        end
        chk("abort bit20", 64'(bus_if.SD_IN), 64'(fr[27]));
        rst = 1'b1;
        #1;
        chk("abort outputs", 64'({bus_if.SD_CS, bus_if.SD_IN, bus_if.busy}), 64'(3'b110));
        saw_done = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge SD_CLK);
            if (bus_if.done === 1'b1) saw_done = 1'b1;
        end
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge SD_CLK);
            if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) saw_done = 1'b1;
        end
        chk("abort no_done", 64'(saw_done), 64'(0));
        run_txn(6'd0, 32'h0, 7'h4A, 1'b0, 3, 40'h01, 0, "after_rst");

        // Start held high: back-to-back transactions, card answers immediately
        bus_if.cmd_idx   = 6'd17;
        bus_if.cmd_arg   = 32'hDEAD_BEEF;
        bus_if.cmd_crc   = 7'h11;
        bus_if.resp_long = 1'b0;
        bus_if.SD_OUT    = 1'b0;
        bus_if.start     = 1'b1;
        first_done = -1;
        for (int n = 1; n <= 200 && first_done < 0; n++) begin
            @(negedge SD_CLK);
            if (bus_if.done === 1'b1) first_done = n;
        end
        chk("b2b first", 64'(first_done), 64'(1 + P + 48 + 1 + 7 + P));
        second_done = -1;
        for (int n = 1; n <= 200 && second_done < 0; n++) begin
            @(negedge SD_CLK);
            if (n == 1)
                chk("b2b rebusy", 64'({bus_if.busy, bus_if.done}), 64'(2'b10));
            if (bus_if.done === 1'b1) second_done = n;
        end
        bus_if.start = 1'b0;
        chk("b2b second", 64'(second_done), 64'(1 + P + 48 + 1 + 7 + P));
        chk("b2b resp", 64'(bus_if.resp), 64'(0));
        bus_if.SD_OUT = 1'b1;
        @(negedge SD_CLK);
        chk("b2b idle", 64'(bus_if.busy), 64'(0));
        $display("txn b2b first=%0d second=%0d", first_done, second_done);

        // Randomized transactions
        for (int t = 0; t < 10; t++) begin
            r_idx   = 6'($urandom);
            r_arg   = $urandom;
            r_crc   = 7'($urandom);
            r_long  = 1'($urandom_range(0, 1));
            r_k     = int'($urandom_range(1, RW + 6));
            r_rv    = {8'($urandom), 32'($urandom)};
            r_extra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(P + 1, P + 60)) : 0;
            run_txn(r_idx, r_arg, r_crc, r_long, r_k, r_rv, r_extra, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
